// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the
// instruction memory program loader.
package imem_loader_pkg;

   localparam int INSTR_W = 32;
   localparam int DEF_SETTLE_CYCLES = 4;

   localparam logic [2:0] LD_IDLE   = 3'd0;
   localparam logic [2:0] LD_LOAD   = 3'd1;
   localparam logic [2:0] LD_SETTLE = 3'd2;
   localparam logic [2:0] LD_RUN    = 3'd3;
   localparam logic [2:0] LD_ERROR  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = LD_IDLE,
      ST_LOAD   = LD_LOAD,
      ST_SETTLE = LD_SETTLE,
      ST_RUN    = LD_RUN,
      ST_ERROR  = LD_ERROR
   } ld_state_t;

   // A new load may only begin from a quiescent state.
   function automatic logic start_ok(
      input ld_state_t st
   );
      return (st == ST_IDLE) ||
             (st == ST_RUN)  ||
             (st == ST_ERROR);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready word stream feeding the loader.
// master = host source, slave = loader.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic               s_valid;
   logic               s_ready;
   logic [INSTR_W-1:0] s_data;
   logic               s_last;

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      output s_ready
   );

endinterface

// File: rtl/imem_loader.sv
// Streams program words into instruction memory and
// holds the core in reset until the load has settled.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W        = 8,
   parameter int MAX_WORDS     = 256,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   imem_loader_if.slave       s_if,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_reset,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [ADDR_W:0]    word_count
);

   localparam int SW =
      (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SET_LAST =
      SW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0] SET_ONE = SW'(1);
   localparam logic [ADDR_W-1:0] PTR_LAST =
      ADDR_W'(MAX_WORDS - 1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   ld_state_t          r_state;
   logic [ADDR_W-1:0]  r_ptr;
   logic [SW-1:0]      r_settle;
   logic [ADDR_W:0]    r_count;
   logic               r_s_ready;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [INSTR_W-1:0] r_wdata;
   logic               r_core_reset;
   logic               r_busy;
   logic               r_done;
   logic               r_error;

   logic               w_accept;
   logic               w_start;

   assign w_accept = s_if.s_valid & r_s_ready;
   assign w_start  = start & start_ok(r_state);

   assign s_if.s_ready = r_s_ready;
   assign imem_we      = r_we;
   assign imem_addr    = r_addr;
   assign imem_wdata   = r_wdata;
   assign core_reset   = r_core_reset;
   assign busy         = r_busy;
   assign done         = r_done;
   assign error        = r_error;
   assign word_count   = r_count;

   // Loader FSM; every output is registered alongside the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_settle     <= '0;
         r_count      <= '0;
         r_s_ready    <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_core_reset <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (w_start) begin
            r_state      <= ST_LOAD;
            r_ptr        <= '0;
            r_count      <= '0;
            r_error      <= 1'b0;
            r_s_ready    <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_core_reset <= 1'b1;
         end else begin
            unique case (r_state)
               ST_LOAD: begin
                  if (w_accept) begin
                     r_we    <= 1'b1;
                     r_addr  <= r_ptr;
                     r_wdata <= s_if.s_data;
                     r_ptr   <= r_ptr + PTR_ONE;
                     r_count <= r_count + CNT_ONE;
                     // s_last takes priority over the capacity check
                     if (s_if.s_last) begin
                        r_state   <= ST_SETTLE;
                        r_settle  <= '0;
                        r_s_ready <= 1'b0;
                     end else if (r_ptr == PTR_LAST) begin
                        r_state   <= ST_ERROR;
                        r_s_ready <= 1'b0;
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                     end
                  end
               end
               ST_SETTLE: begin
                  if (r_settle == SET_LAST) begin
                     r_state      <= ST_RUN;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_core_reset <= 1'b0;
                  end else begin
                     r_settle <= r_settle + SET_ONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Instance a: default size; instance b: 8-word capacity.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int SC = DEF_SETTLE_CYCLES;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;

   logic        a_we, a_cr, a_busy, a_done, a_err;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_cnt;
   logic        b_we, b_cr, b_busy, b_done, b_err;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata;
   logic [8:0]  b_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [31:0] prog [24];
   logic [7:0]  wa_addr [$];
   logic [31:0] wa_data [$];
   int          wa_cyc [$];
   logic [7:0]  wb_addr [$];

   imem_loader_if ifa ();
   imem_loader_if ifb ();

   imem_loader #(.ADDR_W(8), .MAX_WORDS(256), .SETTLE_CYCLES(SC)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .s_if(ifa.slave),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .core_reset(a_cr), .busy(a_busy), .done(a_done),
      .error(a_err), .word_count(a_cnt)
   );

   imem_loader #(.ADDR_W(8), .MAX_WORDS(8), .SETTLE_CYCLES(SC)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .s_if(ifb.slave),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .core_reset(b_cr), .busy(b_busy), .done(b_done),
      .error(b_err), .word_count(b_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (a_we) begin
         wa_addr.push_back(a_addr);
         wa_data.push_back(a_wdata);
         wa_cyc.push_back(cyc);
      end
      if (b_we) wb_addr.push_back(b_addr);
   end

   task automatic send_a(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      ifa.s_valid = 1'b1;
      ifa.s_data  = d;
      ifa.s_last  = l;
      while (!ifa.s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!ifa.s_ready) begin
         bad++;
         $display("FAIL send_a timeout: s_ready=%b required 1", ifa.s_ready);
      end
   endtask

   task automatic pulse_a();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wa_addr.delete();
      wa_data.delete();
      wa_cyc.delete();
   endtask

   task automatic idle_a();
      @(negedge clk);
      ifa.s_valid = 1'b0;
      ifa.s_last  = 1'b0;
   endtask

   // After the last acceptance: SC-1 cycles held, then released.
   task automatic check_settle(input string nm);
      for (int k = 1; k < SC; k++) begin
         @(negedge clk);
         total++;
         if (a_cr !== 1'b1 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL %s hold k=%0d: core_reset=%b done=%b required 1 0",
                     nm, k, a_cr, a_done);
         end
      end
      @(negedge clk);
      total++;
      if (a_cr !== 1'b0 || a_done !== 1'b1 || a_busy !== 1'b0) begin
         bad++;
         $display("FAIL %s release: core_reset=%b done=%b busy=%b required 0 1 0",
                  nm, a_cr, a_done, a_busy);
      end
   endtask

   task automatic check_writes(input string nm, input int n, input int step);
      total++;
      if (wa_addr.size() != n) begin
         bad++;
         $display("FAIL %s count: writes=%0d required %0d", nm, wa_addr.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            total++;
            if (wa_addr[i] !== 8'(i) || wa_data[i] !== prog[i] ||
                wa_cyc[i] !== wa_cyc[0] + i * step) begin
               bad++;
               $display("FAIL %s word %0d: addr=%0d data=%h cyc=%0d required %0d %h %0d",
                        nm, i, wa_addr[i], wa_data[i], wa_cyc[i] - wa_cyc[0],
                        i, prog[i], i * step);
            end
         end
      end
   endtask

   task automatic test_reset();
      ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0;
      ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (a_cr !== 1'b1 || ifa.s_ready !== 1'b0 || a_we !== 1'b0) begin
         bad++;
         $display("FAIL reset ctl: core_reset=%b s_ready=%b we=%b required 1 0 0",
                  a_cr, ifa.s_ready, a_we);
      end
      total++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0) begin
         bad++;
         $display("FAIL reset flags: busy=%b done=%b error=%b required 0 0 0",
                  a_busy, a_done, a_err);
      end
      total++;
      if (a_addr !== 8'd0 || a_wdata !== 32'd0 || a_cnt !== 9'd0) begin
         bad++;
         $display("FAIL reset data: addr=%h wdata=%h count=%0d required 0 0 0",
                  a_addr, a_wdata, a_cnt);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (a_cr !== 1'b1 || ifa.s_ready !== 1'b0) begin
         bad++;
         $display("FAIL idle: core_reset=%b s_ready=%b required 1 0",
                  a_cr, ifa.s_ready);
      end
   endtask

   task automatic test_continuous();
      pulse_a();
      total++;
      if (ifa.s_ready !== 1'b1 || a_busy !== 1'b1 || a_cnt !== 9'd0) begin
         bad++;
         $display("FAIL load entry: s_ready=%b busy=%b count=%0d required 1 1 0",
                  ifa.s_ready, a_busy, a_cnt);
      end
      for (int i = 0; i < 24; i++) send_a(prog[i], i == 23);
      idle_a();
      total++;
      if (a_cnt !== 9'd24 || ifa.s_ready !== 1'b0 || a_busy !== 1'b1) begin
         bad++;
         $display("FAIL cont settle entry: count=%0d s_ready=%b busy=%b required 24 0 1",
                  a_cnt, ifa.s_ready, a_busy);
      end
      check_settle("cont");
      check_writes("cont", 24, 1);
   endtask

   task automatic test_gaps();
      pulse_a();
      for (int i = 0; i < 24; i++) begin
         send_a(prog[i], i == 23);
         idle_a();
      end
      total++;
      if (a_cnt !== 9'd24) begin
         bad++;
         $display("FAIL gaps count: word_count=%0d required 24", a_cnt);
      end
      check_settle("gaps");
      check_writes("gaps", 24, 2);
   endtask

   task automatic test_reload();
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wa_addr.delete(); wa_data.delete(); wa_cyc.delete();
      total++;
      if (a_cr !== 1'b1 || a_done !== 1'b0 || a_cnt !== 9'd0) begin
         bad++;
         $display("FAIL reload entry: core_reset=%b done=%b count=%0d required 1 0 0",
                  a_cr, a_done, a_cnt);
      end
      for (int i = 0; i < 4; i++) send_a(prog[i], i == 3);
      idle_a();
      total++;
      if (a_cnt !== 9'd4) begin
         bad++;
         $display("FAIL reload count: word_count=%0d required 4", a_cnt);
      end
      check_settle("reload");
      check_writes("reload", 4, 1);
   endtask

   task automatic test_single();
      pulse_a();
      send_a(32'h3C1C1000, 1'b1);
      idle_a();
      check_settle("single");
      total++;
      if (a_cnt !== 9'd1 || wa_addr.size() != 1) begin
         bad++;
         $display("FAIL single count: word_count=%0d writes=%0d required 1 1",
                  a_cnt, wa_addr.size());
      end else begin
         total++;
         if (wa_addr[0] !== 8'd0 || wa_data[0] !== 32'h3C1C1000) begin
            bad++;
            $display("FAIL single write: addr=%0d data=%h required 0 3c1c1000",
                     wa_addr[0], wa_data[0]);
         end
      end
   endtask

   task automatic test_overflow();
      int n;
      logic seen;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      wb_addr.delete();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ifb.s_valid = 1'b1;
         ifb.s_data  = 32'hA000_0000 + i;
         ifb.s_last  = 1'b0;
         n = 0;
         while (!ifb.s_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      @(negedge clk);
      ifb.s_data = 32'hA000_0008;
      ifb.s_last = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (ifb.s_ready) seen = 1'b1;
         @(negedge clk);
      end
      ifb.s_valid = 1'b0;
      ifb.s_last  = 1'b0;
      total++;
      if (seen !== 1'b0 || b_err !== 1'b1 || b_cr !== 1'b1 || b_busy !== 1'b0) begin
         bad++;
         $display("FAIL overflow state: ready_seen=%b error=%b core_reset=%b busy=%b required 0 1 1 0",
                  seen, b_err, b_cr, b_busy);
      end
      total++;
      if (b_cnt !== 9'd8 || wb_addr.size() != 8) begin
         bad++;
         $display("FAIL overflow count: word_count=%0d writes=%0d required 8 8",
                  b_cnt, wb_addr.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (wb_addr[i] !== 8'(i)) begin
               bad++;
               $display("FAIL overflow addr %0d: got %0d required %0d",
                        i, wb_addr[i], i);
            end
         end
      end
      // s_last on the final slot wins over the overflow
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      total++;
      if (b_err !== 1'b0 || ifb.s_ready !== 1'b1) begin
         bad++;
         $display("FAIL overflow restart: error=%b s_ready=%b required 0 1",
                  b_err, ifb.s_ready);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ifb.s_valid = 1'b1;
         ifb.s_data  = 32'hB000_0000 + i;
         ifb.s_last  = (i == 7);
      end
      @(negedge clk);
      ifb.s_valid = 1'b0;
      ifb.s_last  = 1'b0;
      repeat (SC) @(negedge clk);
      total++;
      if (b_err !== 1'b0 || b_done !== 1'b1 || b_cr !== 1'b0 || b_cnt !== 9'd8) begin
         bad++;
         $display("FAIL last at cap: error=%b done=%b core_reset=%b count=%0d required 0 1 0 8",
                  b_err, b_done, b_cr, b_cnt);
      end
   endtask

   task automatic test_reset_mid();
      pulse_a();
      for (int i = 0; i < 10; i++) send_a(prog[i], 1'b0);
      idle_a();
      total++;
      if (a_cnt !== 9'd10 || a_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid load: word_count=%0d busy=%b required 10 1", a_cnt, a_busy);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (a_cr !== 1'b1 || a_cnt !== 9'd0 || ifa.s_ready !== 1'b0 ||
          a_busy !== 1'b0 || a_done !== 1'b0) begin
         bad++;
         $display("FAIL async reset: core_reset=%b count=%0d s_ready=%b busy=%b done=%b required 1 0 0 0 0",
                  a_cr, a_cnt, ifa.s_ready, a_busy, a_done);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 24; i++) prog[i] = 32'h2000_1000 + 32'(i * 4);
      prog[0]  = 32'h02114020;
      prog[23] = 32'h3C1C1000;
      test_reset();
      test_continuous();
      test_reload();
      test_gaps();
      test_single();
      test_overflow();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t required finish", $time);
      $fatal(1, "watchdog");
   end

endmodule
